demux32_1to2_fifo: RTL and testbench

Buffered 1-to-2 demultiplexer for 32-bit words, the steering counterpart of the datapath's 2:1 word muxes. It accepts one word stream with a per-word destination select and routes each word into one of two independent output queues. Each output is drained under its own valid/ready handshake. In the multicycle datapath it splits the shared memory read-return path into the instruction-register channel (0) and the memory-data-register channel (1), so a slow consumer on one side never corrupts or reorders data for the other.

---
 rtl/demux32_1to2_fifo_pkg.sv | 18 +
 rtl/demux32_1to2_fifo_if.sv | 41 ++++
 rtl/demux32_1to2_fifo_sync_fifo_1w1r.sv | 64 ++++++
 rtl/demux32_1to2_fifo.sv | 62 ++++++
 tb/tb_demux32_1to2_fifo.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/demux32_1to2_fifo_pkg.sv
// Shared constants for the 1-to-2 word demultiplexer: channel encodings
// and the default datapath geometry.
package demux_pkg;

    // Instruction-register return channel
    localparam logic CH0 = 1'b0;
    // Memory-data-register return channel
    localparam logic CH1 = 1'b1;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Occupancy counter width: must represent 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/demux32_1to2_fifo_if.sv
// Bundle of the routed input stream and both drained output channels.
// The slave modport is the demux itself; master is the source plus both
// consumers.
interface demux32_1to2_fifo_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [CW-1:0]    out0_count;

    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CW-1:0]    out1_count;

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready,
        output out0_data, out0_valid, out0_count,
        output out1_data, out1_valid, out1_count
    );

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready,
        input  out0_data, out0_valid, out0_count,
        input  out1_data, out1_valid, out1_count
    );

endinterface

// File: rtl/demux32_1to2_fifo_sync_fifo_1w1r.sv
// Single-clock FIFO, one write and one read port. Push is ignored when
// full and pop when empty, so callers may present raw requests. Full is
// judged on registered occupancy only; a pop in the same cycle does not
// open a slot for a simultaneous push. Head word is read combinationally
// from registered storage, so there is no fall-through on an empty queue.
module sync_fifo_1w1r
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Storage, pointers and occupancy; reset clears storage so the idle head reads zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/demux32_1to2_fifo.sv
// Buffered 1-to-2 word demultiplexer. Splits the shared memory read-return
// stream into the instruction-register channel (CH0) and the memory-data
// channel (CH1), each behind its own queue so a stalled consumer on one
// side never blocks or reorders the other. in_ready depends only on in_sel
// and registered fullness, never on the output readies.
module demux32_1to2_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    demux32_1to2_fifo_if.slave     bus
);
    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;

    // Select decode: a request is steered to exactly one queue; each queue
    // drops it by itself when full, which matches the in_ready mux below.
    assign push0 = bus.in_valid & (bus.in_sel == CH0);
    assign push1 = bus.in_valid & (bus.in_sel == CH1);

    assign bus.in_ready   = (bus.in_sel == CH0) ? ~full0 : ~full1;
    assign bus.out0_valid = ~empty0;
    assign bus.out1_valid = ~empty1;

    sync_fifo_1w1r #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .wdata (bus.in_data),
        .pop   (bus.out0_ready),
        .rdata (bus.out0_data),
        .full  (full0),
        .empty (empty0),
        .count (bus.out0_count)
    );

    sync_fifo_1w1r #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .wdata (bus.in_data),
        .pop   (bus.out1_ready),
        .rdata (bus.out1_data),
        .full  (full1),
        .empty (empty1),
        .count (bus.out1_count)
    );

endmodule

// File: tb/tb_demux32_1to2_fifo.sv
// Directed bench for demux32_1to2_fifo. Inputs change 1 ns after each
// rising edge; outputs are sampled there too, well away from the next edge.
module tb_demux32_1to2_fifo;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    demux32_1to2_fifo_if #(.WIDTH(32), .DEPTH(2)) bus ();

    demux32_1to2_fifo #(.WIDTH(32), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel = CH0;
        bus.in_data = 32'h0000_0055;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        tick();
        tick();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests++; if ({bus.out0_valid, bus.out1_valid} !== 2'b00) begin fails++; $display("FAIL reset_valids got %b want 00", {bus.out0_valid, bus.out1_valid}); end
        tests++; if ({bus.out0_count, bus.out1_count} !== 4'b0000) begin fails++; $display("FAIL reset_counts got %b want 0000", {bus.out0_count, bus.out1_count}); end
        tests++; if (bus.out0_data !== 32'h0) begin fails++; $display("FAIL reset_data0 got %h want 00000000", bus.out0_data); end
        tests++; if (bus.out1_data !== 32'h0) begin fails++; $display("FAIL reset_data1 got %h want 00000000", bus.out1_data); end
        reset = 1'b0;
        bus.in_data = 32'hDEAD_BEEF;
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL first_push got v=%b d=%h want v=1 d=deadbeef", bus.out0_valid, bus.out0_data); end
        tests++; if (bus.out0_count !== 2'd1) begin fails++; $display("FAIL first_push_count got %0d want 1", bus.out0_count); end
        bus.out0_ready = 1'b1;
        tick();
        bus.out0_ready = 1'b0;
        tests++; if (bus.out0_valid !== 1'b0 || bus.out0_count !== 2'd0) begin fails++; $display("FAIL first_drain got v=%b c=%0d want v=0 c=0", bus.out0_valid, bus.out0_count); end
    endtask

    task automatic test_routing;
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel = CH0;
        bus.in_data = 32'h0000_0011;
        tick();
        bus.in_sel = CH1;
        bus.in_data = 32'h0000_0022;
        tests++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h11) begin fails++; $display("FAIL route_ch0 got v=%b d=%h want v=1 d=00000011", bus.out0_valid, bus.out0_data); end
        tests++; if (bus.out1_valid !== 1'b0) begin fails++; $display("FAIL route_ch1_idle got v=%b want 0", bus.out1_valid); end
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h22) begin fails++; $display("FAIL route_ch1 got v=%b d=%h want v=1 d=00000022", bus.out1_valid, bus.out1_data); end
        tests++; if (bus.out0_valid !== 1'b0) begin fails++; $display("FAIL route_ch0_idle got v=%b want 0", bus.out0_valid); end
        tick();
        tests++; if ({bus.out0_valid, bus.out1_valid} !== 2'b00) begin fails++; $display("FAIL route_drained got %b want 00", {bus.out0_valid, bus.out1_valid}); end
    endtask

    task automatic test_backpressure;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel = CH0;
        bus.in_data = 32'hA0;
        tick();
        bus.in_data = 32'hA1;
        tick();
        bus.in_data = 32'hA2;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %b want 0", bus.in_ready); end
        tick();
        tests++; if (bus.out0_count !== 2'd2 || bus.out0_data !== 32'hA0) begin fails++; $display("FAIL bp_refused got c=%0d d=%h want c=2 d=000000a0", bus.out0_count, bus.out0_data); end
        bus.in_sel = CH1;
        bus.in_data = 32'hB0;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_other_ready got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.out1_count !== 2'd1 || bus.out1_data !== 32'hB0) begin fails++; $display("FAIL bp_other_push got c=%0d d=%h want c=1 d=000000b0", bus.out1_count, bus.out1_data); end
        bus.out0_ready = 1'b1;
        tick();
        bus.out0_ready = 1'b0;
        tests++; if (bus.out0_data !== 32'hA1 || bus.out0_count !== 2'd1) begin fails++; $display("FAIL bp_drain_a1 got d=%h c=%0d want d=000000a1 c=1", bus.out0_data, bus.out0_count); end
        bus.out0_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel = CH0;
        bus.in_data = 32'hA2;
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.out0_data !== 32'hA2 || bus.out0_count !== 2'd1) begin fails++; $display("FAIL bp_a2_accept got d=%h c=%0d want d=000000a2 c=1", bus.out0_data, bus.out0_count); end
        bus.out1_ready = 1'b1;
        tick();
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        tests++; if ({bus.out0_count, bus.out1_count} !== 4'b0000) begin fails++; $display("FAIL bp_all_drained got %b want 0000", {bus.out0_count, bus.out1_count}); end
    endtask

    task automatic test_wrap;
        bus.out1_ready = 1'b1;
        bus.in_sel = CH1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 32'h100 + 32'(i);
            tick();
            tests++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h100 + 32'(i) || bus.out1_count !== 2'd1) begin fails++; $display("FAIL wrap_word%0d got v=%b d=%h c=%0d want v=1 d=%h c=1", i, bus.out1_valid, bus.out1_data, bus.out1_count, 32'h100 + 32'(i)); end
            tests++; if (bus.out0_valid !== 1'b0) begin fails++; $display("FAIL wrap_ch0_leak%0d got v=%b want 0", i, bus.out0_valid); end
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out1_ready = 1'b0;
        tests++; if (bus.out1_valid !== 1'b0 || bus.out1_count !== 2'd0) begin fails++; $display("FAIL wrap_drained got v=%b c=%0d want v=0 c=0", bus.out1_valid, bus.out1_count); end
    endtask

    task automatic test_full_pop;
        bus.out0_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel = CH0;
        bus.in_data = 32'hC0;
        tick();
        bus.in_data = 32'hC1;
        tick();
        bus.in_data = 32'hC2;
        bus.out0_ready = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL fp_ready_while_pop got %b want 0", bus.in_ready); end
        tick();
        bus.out0_ready = 1'b0;
        tests++; if (bus.out0_count !== 2'd1 || bus.out0_data !== 32'hC1) begin fails++; $display("FAIL fp_refused got c=%0d d=%h want c=1 d=000000c1", bus.out0_count, bus.out0_data); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL fp_retry_ready got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.out0_count !== 2'd2 || bus.out0_data !== 32'hC1) begin fails++; $display("FAIL fp_retry got c=%0d d=%h want c=2 d=000000c1", bus.out0_count, bus.out0_data); end
        bus.out0_ready = 1'b1;
        tick();
        tests++; if (bus.out0_data !== 32'hC2) begin fails++; $display("FAIL fp_order got %h want 000000c2", bus.out0_data); end
        tick();
        bus.out0_ready = 1'b0;
        tests++; if (bus.out0_valid !== 1'b0) begin fails++; $display("FAIL fp_drained got v=%b want 0", bus.out0_valid); end
    endtask

    task automatic test_reset_mid;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel = CH0; bus.in_data = 32'hD0; tick();
        bus.in_data = 32'hD1; tick();
        bus.in_sel = CH1; bus.in_data = 32'hE0; tick();
        bus.in_data = 32'hE1; tick();
        bus.in_valid = 1'b0;
        tests++; if ({bus.out0_count, bus.out1_count} !== 4'b1010) begin fails++; $display("FAIL rm_filled got %b want 1010", {bus.out0_count, bus.out1_count}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if ({bus.out0_count, bus.out1_count} !== 4'b0000 || {bus.out0_valid, bus.out1_valid} !== 2'b00) begin fails++; $display("FAIL rm_cleared got c=%b v=%b want c=0000 v=00", {bus.out0_count, bus.out1_count}, {bus.out0_valid, bus.out1_valid}); end
        tests++; if (bus.out0_data !== 32'h0 || bus.out1_data !== 32'h0) begin fails++; $display("FAIL rm_data got %h %h want 0 0", bus.out0_data, bus.out1_data); end
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if ({bus.out0_valid, bus.out1_valid} !== 2'b00) begin fails++; $display("FAIL rm_stale%0d got %b want 00", i, {bus.out0_valid, bus.out1_valid}); end
        end
        bus.in_valid = 1'b1;
        bus.in_sel = CH1;
        bus.in_data = 32'hF0;
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'hF0) begin fails++; $display("FAIL rm_first_push got v=%b d=%h want v=1 d=000000f0", bus.out1_valid, bus.out1_data); end
        tick();
        tests++; if (bus.out1_valid !== 1'b0) begin fails++; $display("FAIL rm_after got v=%b want 0", bus.out1_valid); end
    endtask

    initial begin
        bus.in_data = '0;
        bus.in_sel = CH0;
        bus.in_valid = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        test_reset();
        test_routing();
        test_backpressure();
        test_wrap();
        test_full_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, tests=%0d", tests);
        $fatal(1);
    end

endmodule
